// File: rtl/ascon_share_loader.sv
// ascon_share_loader
//   Byte-lane serial loader and result serializer for one masked Ascon field.
//   The loader deserializes NS share streams (share 0 = data, 1..NS-1 = masks)
//   of one LEN-bit field over a valid/ready handshake, then presents them
//   in parallel until the core signals consume. The serializer captures the
//   core result (or a random substitute when unauthenticated) and streams it
//   out least-significant lane first.
//
// Parameters
//   LEN : field length in bits (multiple of W, >= W)
//   W   : lane width in bits per beat
//   NS  : number of shares
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i : input beat handshake, one lane per share
//   fields_o, loaded_o : assembled shares (share s at [s*LEN +: LEN]), full flag
//   consume_i          : core took the fields; rearm the loader
//   out_load_i, res_data_i, res_ok_i, rand_data_i : result capture
//   out_valid_o/out_ready_i/out_data_o/out_last_o : output beat handshake

// One share shift register: new lane enters at bit 0, so the first beat
// ends up most significant.
module ascon_share_lane #(
   parameter int LEN = 128,
   parameter int W   = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           shift_i,
   input  logic [W-1:0]   lane_i,
   output logic [LEN-1:0] share_o
);
   logic [LEN-1:0] share_q;

   always_ff @(posedge clk) begin
      if (rst)          share_q <= '0;
      else if (shift_i) share_q <= (share_q << W) | LEN'(lane_i);
   end

   assign share_o = share_q;
endmodule

module ascon_share_loader #(
   parameter int LEN = 128,
   parameter int W   = 8,
   parameter int NS  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid_i,
   input  logic [NS*W-1:0] in_data_i,
   output logic            in_ready_o,
   output logic [NS*LEN-1:0] fields_o,
   output logic            loaded_o,
   input  logic            consume_i,
   input  logic            out_load_i,
   input  logic [LEN-1:0]  res_data_i,
   input  logic            res_ok_i,
   input  logic [LEN-1:0]  rand_data_i,
   output logic            out_valid_o,
   output logic [W-1:0]    out_data_o,
   input  logic            out_ready_i,
   output logic            out_last_o
);
   localparam int BEATS = LEN / W;
   localparam int CW    = $clog2(BEATS + 1);

   typedef enum logic { FILL, FULL } ld_state_e;
   typedef enum logic { IDLE, SEND } sr_state_e;

   ld_state_e      ld_state_q;
   logic [CW-1:0]  ld_cnt_q;
   sr_state_e      sr_state_q;
   logic [CW-1:0]  sr_cnt_q;
   logic [LEN-1:0] sreg_q;

   logic accept;
   assign accept = (ld_state_q == FILL) && in_valid_i;

   // ---------------- loader ----------------
   for (genvar s = 0; s < NS; s++) begin : g_share
      ascon_share_lane #(.LEN(LEN), .W(W)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .shift_i (accept),
         .lane_i  (in_data_i[s*W +: W]),
         .share_o (fields_o[s*LEN +: LEN])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_state_q <= FILL;
         ld_cnt_q   <= '0;
      end else begin
         case (ld_state_q)
            FILL: if (in_valid_i) begin
               ld_cnt_q <= ld_cnt_q + CW'(1);
               if (ld_cnt_q == CW'(BEATS - 1)) ld_state_q <= FULL;
            end
            // Shares are kept as-is on consume; the next load shifts them out.
            FULL: if (consume_i) begin
               ld_state_q <= FILL;
               ld_cnt_q   <= '0;
            end
            default: ld_state_q <= FILL;
         endcase
      end
   end

   assign in_ready_o = (ld_state_q == FILL);
   assign loaded_o   = (ld_state_q == FULL);

   // ---------------- serializer ----------------
   // The mux selects before capture, so an unauthenticated result never
   // reaches the shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_state_q <= IDLE;
         sr_cnt_q   <= '0;
         sreg_q     <= '0;
      end else begin
         case (sr_state_q)
            IDLE: if (out_load_i) begin
               sreg_q     <= res_ok_i ? res_data_i : rand_data_i;
               sr_cnt_q   <= '0;
               sr_state_q <= SEND;
            end
            SEND: if (out_ready_i) begin
               sreg_q   <= sreg_q >> W;
               sr_cnt_q <= sr_cnt_q + CW'(1);
               if (sr_cnt_q == CW'(BEATS - 1)) sr_state_q <= IDLE;
            end
            default: sr_state_q <= IDLE;
         endcase
      end
   end

   // sreg drains to zero after the last beat, so out_data is 0 while idle.
   assign out_valid_o = (sr_state_q == SEND);
   assign out_data_o  = sreg_q[W-1:0];
   assign out_last_o  = (sr_state_q == SEND) && (sr_cnt_q == CW'(BEATS - 1));
endmodule

// File: doc/ascon_share_loader.md
# ascon_share_loader

Parametrised byte-lane serial loader and result serializer for the masked Ascon datapath. It deserializes NS parallel share streams (a value plus its random masks) of one LEN-bit field over a valid/ready handshake. It presents the assembled shares to the cipher core. It then serializes the core's LEN-bit result lane by lane, substituting a random value when the result is not authenticated. One instance serves each field (key, nonce, AD, PT), replacing fixed-width, free-running, handshake-less shift logic.

## Interface
- LEN, 128, field length in bits; must be a multiple of W and at least W.
- W, 8, lane width in bits per beat.
- NS, 5, number of shares per field (share 0 is the data share; shares 1..NS-1 are masks).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_data  in  NS*W  one lane per share; share s occupies in_data[s*W +: W].
- in_ready  out  1  loader accepts a beat.
- fields  out  NS*LEN  assembled shares; share s occupies fields[s*LEN +: LEN].
- loaded  out  1  all LEN bits of every share are present.
- consume  in  1  single-cycle pulse: the core has taken fields, so rearm the loader.
- out_load  in  1  single-cycle pulse: capture the result for serialization.
- res_data  in  LEN  result from the core.
- res_ok  in  1  result authenticated, sampled with out_load.
- rand_data  in  LEN  substitute value, sampled with out_load.
- out_valid  out  1  output beat valid.
- out_data  out  W  output lane.
- out_ready  in  1  sink accepts a beat.
- out_last  out  1  marks the final beat of the field.

## Operation
- BEATS = LEN/W. The beat counters are clog2(BEATS+1) bits wide.
- Loader FSM has two states, FILL and FULL. Reset state is FILL.
- FILL:
  - in_ready=1.
  - On each in_valid&in_ready, every share register shifts left by W and the new lane enters at bit 0. The first beat therefore ends up most significant.
  - The counter increments on each accepted beat. After the BEATS-th accepted beat, the FSM moves to FULL.
- FULL:
  - in_ready=0 and loaded=1. in_valid is ignored.
  - consume moves the FSM to FILL and clears the counter.
  - Share registers keep their value until the first new beat shifts them.
- consume while in FILL is ignored.
- Serializer FSM has two states, IDLE and SEND. Reset state is IDLE.
- IDLE: on out_load, the shift register is loaded with res_ok ? res_data : rand_data, the beat counter is cleared, and the FSM moves to SEND.
- SEND:
  - out_valid=1 and out_data = sreg[W-1:0], so the least significant lane goes out first.
  - out_last=1 when the counter equals BEATS-1.
  - On out_valid&out_ready, sreg shifts right by W with zero fill and the counter increments. The handshake on the last beat returns the FSM to IDLE.
- out_load while in SEND is ignored, and the captured value is not disturbed.
- res_data is never exposed when res_ok=0. No partial result leaks.
- Loader and serializer run independently. Load, consume, and serialize may occur in the same cycle.

## Timing
- Reset values:
  - in_ready=1.
  - loaded=0.
  - fields=0.
  - out_valid=0.
  - out_data=0.
  - out_last=0.
  - All counters and shift registers are 0.
- in_ready, loaded, out_valid and out_last decode from registered state only, with no combinational path from inputs.
- Load latency: loaded rises in the cycle after the BEATS-th accepted beat. The minimum is BEATS cycles from the first beat when in_valid is held high.
- in_ready falls in the same cycle loaded rises. It rises again in the cycle after consume.
- Output latency: out_valid rises in the cycle after out_load. At full throughput, one field takes BEATS cycles.
- Back-pressure: with out_ready=0, out_data and out_last hold stable.
- With in_valid=0 in FILL, the loader holds its state and counter.
- rst in any state returns both FSMs to reset values at the next edge. Partially loaded data and in-flight output are discarded.

## Test plan
- LEN=24, W=8, NS=2, in_valid held high, beats {s0,s1} = {11,A1},{22,B2},{33,C3} -> loaded=1 after 3 beats; fields share0=0x112233, share1=0xA1B2C3; in_ready=0 from then on.
- Same configuration with in_valid toggling and one extra beat offered while FULL -> extra beat ignored and fields unchanged; after consume, in_ready=1 the next cycle and a new 3-beat load overwrites the fields.
- out_load with res_ok=1, res_data=0x445566, out_ready=1 -> out_data sequence 66,55,44; out_last only on 44; out_valid drops after the third beat.
- out_load with res_ok=0, res_data=0x445566, rand_data=0x0F0E0D -> outputs 0D,0E,0F; no byte of 0x445566 ever appears.
- out_ready held low for 4 cycles mid-field -> out_data and out_last hold; out_load pulse during SEND is ignored; sequence completes unchanged.
- rst asserted after 2 of 3 input beats and mid-serialization -> all outputs at reset values the next cycle; a fresh 3-beat load yields correct fields.
